// File: rtl/program_loader.sv
// Byte-stream program loader: parses {id, len_lo, len_hi, 4*LEN data bytes} frames
// and writes little-endian 32-bit words into per-agent program memories.
// Optional trailing XOR checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader #(
  parameter int NUM_AGENTS = 5,
  parameter int ADDR_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic [NUM_AGENTS-1:0] mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [NUM_AGENTS-1:0] hold,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  fire;
  logic                  word_last;
  logic                  len_zero;
  logic [NUM_AGENTS-1:0] id_onehot;

  logic [7:0]            len_lo_q;
  logic [15:0]           rem_q;        // words still to be written in this frame
  logic [1:0]            byte_idx_q;   // byte position within the current word
  logic [23:0]           wbuf_q;       // first three bytes of the current word
  logic [ADDR_W-1:0]     word_cnt_q;   // address of the next word to write
  logic [NUM_AGENTS-1:0] mask_q;       // one-hot target agent; zero for a bad id
  logic                  id_ok_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif
  logic [NUM_AGENTS-1:0] mem_we_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic [NUM_AGENTS-1:0] hold_q;
  logic                  err_q;

  // The DONE cycle is a one-cycle bubble; nothing is accepted while in reset.
  assign s_ready   = ~rst & (state_q != DONE);
  assign fire      = s_valid & s_ready;
  assign word_last = (byte_idx_q == 2'd3) && (rem_q == 16'd1);
  assign len_zero  = ({s_data, len_lo_q} == 16'd0);

  // Decode the incoming byte as an agent id; out-of-range ids decode to all zeros.
  always_comb begin
    id_onehot = '0;
    for (int k = 0; k < NUM_AGENTS; k++) begin
      if (32'(s_data) == k) id_onehot[k] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; gaps in s_valid simply hold the current state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (fire) state_d = LEN_LO;
      LEN_LO: if (fire) state_d = LEN_HI;
      // An empty program finishes immediately, with no checksum byte either.
      LEN_HI: if (fire) state_d = len_zero ? DONE : DATA;
      DATA: begin
        if (fire && word_last) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      // A bad checksum abandons the frame without a done pulse.
      CHK:    if (fire) state_d = (s_data == csum_q) ? DONE : IDLE;
`endif
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame datapath: id/length capture, word assembly, memory writes, hold and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo_q    <= '0;
      rem_q       <= '0;
      byte_idx_q  <= '0;
      wbuf_q      <= '0;
      word_cnt_q  <= '0;
      mask_q      <= '0;
      id_ok_q     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hold_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q <= '0;
      // Release the agent in the same cycle that done pulses.
      if (state_d == DONE && state_q != DONE && id_ok_q) begin
        hold_q <= hold_q & ~mask_q;
      end
      if (fire) begin
        case (state_q)
          IDLE: begin
            mask_q     <= id_onehot;
            id_ok_q    <= |id_onehot;
            byte_idx_q <= '0;
            word_cnt_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
            if (|id_onehot) hold_q <= hold_q | id_onehot;
            else            err_q  <= 1'b1;
          end
          LEN_LO: len_lo_q <= s_data;
          LEN_HI: rem_q    <= {s_data, len_lo_q};
          DATA: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q     <= csum_q ^ s_data;
`endif
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              // mask_q is zero for a bad id, so that frame never writes.
              mem_we_q    <= mask_q;
              mem_addr_q  <= word_cnt_q;
              mem_wdata_q <= {s_data, wbuf_q};
              word_cnt_q  <= word_cnt_q + 1'b1;
              rem_q       <= rem_q - 16'd1;
            end else begin
              wbuf_q[{byte_idx_q, 3'b000} +: 8] <= s_data;
            end
          end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          CHK: if (s_data != csum_q) err_q <= 1'b1;
`endif
          default: ;
        endcase
      end
    end
  end

  // Outputs read as zero while reset is held, even before the first reset edge.
  assign mem_we    = rst ? '0 : mem_we_q;
  assign mem_addr  = rst ? '0 : mem_addr_q;
  assign mem_wdata = rst ? '0 : mem_wdata_q;
  assign hold      = rst ? '0 : hold_q;
  assign err       = rst ? 1'b0 : err_q;
  assign done      = ~rst & (state_q == DONE) & id_ok_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
  localparam int NA = 5;
  localparam int AW = 16;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_ready;
  logic [NA-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [NA-1:0] hold;
  logic          done;
  logic          err;

  program_loader #(.NUM_AGENTS(NA), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .hold(hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [NA-1:0] we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t        wq[$];
  int         done_n = 0;
  logic [7:0] payload[$];
  logic [NA-1:0] exp_hold = '0;
  logic          exp_err  = 1'b0;

  // Observe every memory write and done pulse away from the clock edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we != '0) wq.push_back('{mem_we, mem_addr, mem_wdata});
      if (done) done_n++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // gm: 0 = back-to-back, 1 = one idle cycle before each byte, 2 = random idle cycles.
  task automatic send_byte(input logic [7:0] b, input int gm);
    int gaps;
    int tries;
    gaps = (gm == 1) ? 1 : (gm == 2) ? int'($urandom_range(0, 2)) : 0;
    for (int g = 0; g < gaps; g++) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_data  = 8'($urandom);
    end
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    tries   = 0;
    while (!s_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 50) chk("ready_wait", {63'd0, s_ready}, 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] id, input int len, input int gm);
    logic [7:0]    fb[$];
    logic [7:0]    x;
    logic [NA-1:0] m;
    bit            ok;
    bit            last;
    ok = (int'(id) < NA);
    m  = ok ? NA'(1) << id : '0;
    fb = {id, 8'(len), 8'(len >> 8)};
    x  = 8'h00;
    for (int i = 0; i < 4 * len; i++) begin
      fb.push_back(payload[i]);
      x ^= payload[i];
    end
    if (CSUM && len > 0) fb.push_back(x);
    wq.delete();
    done_n = 0;
    for (int i = 0; i < fb.size(); i++) begin
      send_byte(fb[i], gm);
      last = (i == fb.size() - 1);
      if (i == 0) begin
        if (ok) exp_hold = exp_hold | m;
        else    exp_err  = 1'b1;
      end
      if (last && ok) exp_hold = exp_hold & ~m;
      chk("hold", 64'(hold), 64'(exp_hold));
      chk("done_timing", {63'd0, done}, {63'd0, last && ok});
      if (last) begin
        chk("we_with_done", 64'(mem_we), (ok && len > 0 && !CSUM) ? 64'(m) : 64'd0);
        chk("ready_low_done", {63'd0, s_ready}, 64'd0);
      end
    end
    repeat (3) @(negedge clk);
    #1;
    chk("num_writes", 64'(wq.size()), ok ? 64'(len) : 64'd0);
    for (int k = 0; k < wq.size() && k < len; k++) begin
      chk("wr_we",   64'(wq[k].we),   64'(m));
      chk("wr_addr", 64'(wq[k].addr), 64'(k));
      chk("wr_data", 64'(wq[k].data),
          64'({payload[4*k+3], payload[4*k+2], payload[4*k+1], payload[4*k]}));
    end
    chk("num_done", 64'(done_n), ok ? 64'd1 : 64'd0);
    chk("err", {63'd0, err}, {63'd0, exp_err});
    chk("hold_end", 64'(hold), 64'(exp_hold));
  endtask

  task automatic rand_payload(input int len);
    payload.delete();
    for (int i = 0; i < 4 * len; i++) payload.push_back(8'($urandom));
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_we",    64'(mem_we),    64'd0);
    chk("rst_addr",  64'(mem_addr),  64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_hold",  64'(hold),      64'd0);
    chk("rst_done",  {63'd0, done},  64'd0);
    chk("rst_err",   {63'd0, err},   64'd0);
    chk("rst_ready", {63'd0, s_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_idle", {63'd0, s_ready}, 64'd1);

    // Agent 2, two words, back to back
    payload = {8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_frame(8'h02, 2, 0);
    if (wq.size() == 2) begin
      chk("w0_const", 64'(wq[0].data), 64'h44332211);
      chk("w1_const", 64'(wq[1].data), 64'hDDCCBBAA);
    end

    // Same frame with s_valid low every other cycle
    run_frame(8'h02, 2, 1);

    // Empty program for agent 0
    payload.delete();
    run_frame(8'h00, 0, 0);

    // Random frames to valid agents
    for (int f = 0; f < 8; f++) begin
      int len;
      len = int'($urandom_range(0, 4));
      rand_payload(len);
      run_frame(8'($urandom_range(0, NA - 1)), len, int'($urandom_range(0, 2)));
    end

    // Out-of-range agent id: consumed, flagged, no effects
    payload = {8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(8'h07, 1, 0);

    // Random frames after the error, including bad ids; err must stay set
    for (int f = 0; f < 6; f++) begin
      int len;
      len = int'($urandom_range(0, 3));
      rand_payload(len);
      run_frame(8'($urandom_range(0, NA + 1)), len, int'($urandom_range(0, 2)));
    end

    // Reset in the middle of a frame, with a byte offered during reset
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'hE1, 0);
    send_byte(8'hE2, 0);
    @(negedge clk);
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h03;
    #1;
    chk("mid_rst_hold",  64'(hold),      64'd0);
    chk("mid_rst_err",   {63'd0, err},   64'd0);
    chk("mid_rst_ready", {63'd0, s_ready}, 64'd0);
    @(negedge clk);
    rst     = 1'b0;
    s_valid = 1'b0;
    exp_hold = '0;
    exp_err  = 1'b0;
    payload = {8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E, 8'hAF, 8'hB0, 8'hC1};
    run_frame(8'h01, 2, 0);
    if (wq.size() > 0) chk("post_rst_w0", 64'(wq[0].data), 64'h8D7C6B5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter NUM_AGENTS, default 5: number of per-agent program memories served.
REQ-002 SHALL have parameter ADDR_W, default 16: program memory word-address width.
REQ-003 SHALL have port clk  input  1: clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port s_valid  input  1: byte-stream valid.
REQ-006 SHALL have port s_data  input  8: byte-stream data.
REQ-007 SHALL have port s_ready  output  1: loader accepts byte; transfer = s_valid & s_ready.
REQ-008 SHALL have port mem_we  output  NUM_AGENTS: one-hot write enable, bit k = agent k program memory.
REQ-009 SHALL have port mem_addr  output  ADDR_W: word address of write.
REQ-010 SHALL have port mem_wdata  output  32: instruction word written.
REQ-011 SHALL have port hold  output  NUM_AGENTS: bit k holds agent k in reset while its program loads.
REQ-012 SHALL have port done  output  1: one-cycle pulse on successful frame completion.
REQ-013 SHALL have port err  output  1: sticky error flag.

Function
REQ-014 SHALL parse frames: agent-id byte, length low byte, length high byte (LEN in words), then 4*LEN data bytes.
REQ-015 SHALL use states IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE; IDLE->LEN_LO on id byte, LEN_LO->LEN_HI->DATA on a byte each, DATA->DONE after last data byte, DONE->IDLE unconditionally.
REQ-016 SHALL drive s_ready=1 in IDLE, LEN_LO, LEN_HI, DATA, CHK and 0 in DONE.
REQ-017 SHALL, for LEN=0, go LEN_HI->DONE with no writes.
REQ-018 SHALL assemble words little-endian: first data byte -> mem_wdata[7:0], fourth -> [31:24].
REQ-019 SHALL assert mem_we[id] for exactly one cycle, the cycle after the fourth byte of a word is accepted, with mem_addr/mem_wdata valid that cycle.
REQ-020 SHALL write the first word at mem_addr 0, incrementing by 1 per word; address never wraps within a frame (LEN <= 2^ADDR_W).
REQ-021 SHALL tolerate s_valid gaps at any byte position without state change or spurious writes.
REQ-022 SHALL set hold[id] the cycle after the id byte is accepted and clear it in the cycle done pulses; other hold bits unaffected.
REQ-023 SHALL pulse done the cycle after the final frame byte is accepted (concurrent with the last mem_we).
REQ-024 SHALL, when id >= NUM_AGENTS, set err, consume the full frame, suppress all mem_we and hold, and not pulse done.
REQ-025 SHALL keep err set until rst.

Reset
REQ-026 SHALL on rst enter IDLE, discard partial word/frame, and drive mem_we=0, mem_addr=0, mem_wdata=0, hold=0, done=0, err=0, s_ready=0 during rst.
REQ-027 SHALL take rst over any simultaneous byte transfer.

Configuration
REQ-028 SHALL implement checksum only when macro PROGRAM_LOADER_CHECKSUM_EN is defined: DATA->CHK after last data byte, one extra byte equal to XOR of all data bytes; match -> DONE; mismatch -> err set, no done, hold[id] stays set, return IDLE.
REQ-029 SHALL, without PROGRAM_LOADER_CHECKSUM_EN, omit CHK entirely and use frame format of REQ-014.

Verification
REQ-030 Frame {02,02,00,11,22,33,44,AA,BB,CC,DD} -> mem_we=5'b00100 at addr0 data 44332211, addr1 DDCCBBAA; hold[2] high throughout; done one cycle after byte DD.
REQ-031 Same frame with s_valid toggled every other cycle -> identical writes, no extra mem_we.
REQ-032 Frame {07,01,00,01,02,03,04} -> err=1, mem_we never asserted, hold=0, no done.
REQ-033 Frame {00,00,00} -> no writes, done one cycle after third byte, hold[0] cleared.
REQ-034 rst asserted after 2 data bytes, then full valid frame for agent 1 -> first write addr 0 with new-frame bytes only.
REQ-035 With PROGRAM_LOADER_CHECKSUM_EN: {01,01,00,01,02,03,04,04} -> done; checksum byte 05 -> err=1, no done, hold[1] stays 1.
